// File: rtl/mips_pkg.sv
// Shared MIPS-I decode constants: opcodes, functs, ALU op encodings and ID/EX control bit positions.
package mips_pkg;

    localparam int ID_CTRL_W = 10;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_RTYPE = 2'b10,
        ALU_IMM   = 2'b11
    } alu_op_t;

    localparam int CTRL_REG_WRITE  = 9;
    localparam int CTRL_MEM_READ   = 8;
    localparam int CTRL_MEM_WRITE  = 7;
    localparam int CTRL_MEM_TO_REG = 6;
    localparam int CTRL_ALU_SRC    = 5;
    localparam int CTRL_REG_DST    = 4;
    localparam int CTRL_BRANCH     = 3;
    localparam int CTRL_JUMP       = 2;
    localparam int CTRL_ALU_OP_HI  = 1;
    localparam int CTRL_ALU_OP_LO  = 0;

    // R-type functions executed by EX: shifts, jr, add/sub, logic, set-less-than.
    function automatic logic funct_supported(input logic [5:0] funct);
        case (funct)
            6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08,
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
            6'h27, 6'h2A, 6'h2B: funct_supported = 1'b1;
            default:             funct_supported = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/instruction_decode_register_file.sv
// 2-read/1-write register file; $0 hardwired to zero, same-cycle write data bypassed to readers.
module register_file #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] raddr_a,
    input  logic [REG_AW-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data
);
    localparam int NREG = 2 ** REG_AW;

    logic [DATA_W-1:0] words [NREG];

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign words[gi] = '0;
            end else begin : g_word
                logic [DATA_W-1:0] word_reg;
                always_ff @(posedge clk) begin
                    if (rst) begin
                        word_reg <= '0;
                    end else if (wb_en && wb_addr == REG_AW'(gi)) begin
                        word_reg <= wb_data;
                    end
                end
                assign words[gi] = word_reg;
            end
        end
    endgenerate

    logic bypass_a;
    logic bypass_b;

    assign bypass_a = wb_en && (wb_addr != '0) && (wb_addr == raddr_a);
    assign bypass_b = wb_en && (wb_addr != '0) && (wb_addr == raddr_b);
    assign rdata_a  = bypass_a ? wb_data : words[raddr_a];
    assign rdata_b  = bypass_b ? wb_data : words[raddr_b];

endmodule

// File: rtl/instruction_decode.sv
// MIPS ID stage: register file, control decode, load-use stall, flush and the ID/EX register.
// Optional build macro ILLEGAL_INSTR_TRAP_EN adds id_illegal for unsupported encodings.
module instruction_decode
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_valid,
    input  logic [DATA_W-1:0]    if_instr,
    input  logic [DATA_W-1:0]    if_pc,
    input  logic                 flush,
    input  logic                 ex_mem_read,
    input  logic [REG_AW-1:0]    ex_rt,
    input  logic                 wb_en,
    input  logic [REG_AW-1:0]    wb_addr,
    input  logic [DATA_W-1:0]    wb_data,
    output logic                 stall,
    output logic                 id_valid,
    output logic [DATA_W-1:0]    id_pc,
    output logic [DATA_W-1:0]    id_rs_data,
    output logic [DATA_W-1:0]    id_rt_data,
    output logic [DATA_W-1:0]    id_imm,
    output logic [REG_AW-1:0]    id_rs,
    output logic [REG_AW-1:0]    id_rt,
    output logic [REG_AW-1:0]    id_rd,
    output logic [4:0]           id_shamt,
    output logic [5:0]           id_funct,
    output logic [25:0]          id_jtarget,
    output logic [ID_CTRL_W-1:0] id_ctrl
`ifdef ILLEGAL_INSTR_TRAP_EN
    ,
    output logic                 id_illegal
`endif
);
`ifdef ILLEGAL_INSTR_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    logic [5:0]           opcode;
    logic [REG_AW-1:0]    rs;
    logic [REG_AW-1:0]    rt;
    logic [REG_AW-1:0]    rd_field;
    logic [DATA_W-1:0]    rs_data;
    logic [DATA_W-1:0]    rt_data;
    logic [ID_CTRL_W-1:0] ctrl_next;
    logic [DATA_W-1:0]    imm_next;
    logic [REG_AW-1:0]    rd_next;
    logic                 supported;
    logic                 rt_used;
    logic                 load;
    logic                 keep;

    assign opcode   = if_instr[31:26];
    assign rs       = if_instr[21 +: REG_AW];
    assign rt       = if_instr[16 +: REG_AW];
    assign rd_field = if_instr[11 +: REG_AW];

    register_file #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_regs (
        .clk     (clk),
        .rst     (rst),
        .raddr_a (rs),
        .raddr_b (rt),
        .rdata_a (rs_data),
        .rdata_b (rt_data),
        .wb_en   (wb_en),
        .wb_addr (wb_addr),
        .wb_data (wb_data)
    );

    always_comb begin
        ctrl_next = '0;
        supported = 1'b1;
        imm_next  = DATA_W'($signed(if_instr[15:0]));
        rd_next   = rd_field;
        case (opcode)
            OP_RTYPE: begin
                supported                                  = funct_supported(if_instr[5:0]);
                ctrl_next[CTRL_REG_DST]                    = 1'b1;
                ctrl_next[CTRL_REG_WRITE]                  = 1'b1;
                ctrl_next[CTRL_ALU_OP_HI:CTRL_ALU_OP_LO]   = ALU_RTYPE;
            end
            OP_LW: begin
                ctrl_next[CTRL_ALU_SRC]    = 1'b1;
                ctrl_next[CTRL_MEM_READ]   = 1'b1;
                ctrl_next[CTRL_MEM_TO_REG] = 1'b1;
                ctrl_next[CTRL_REG_WRITE]  = 1'b1;
            end
            OP_SW: begin
                ctrl_next[CTRL_ALU_SRC]   = 1'b1;
                ctrl_next[CTRL_MEM_WRITE] = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                ctrl_next[CTRL_BRANCH]                   = 1'b1;
                ctrl_next[CTRL_ALU_OP_HI:CTRL_ALU_OP_LO] = ALU_SUB;
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: begin
                ctrl_next[CTRL_ALU_SRC]                  = 1'b1;
                ctrl_next[CTRL_REG_WRITE]                = 1'b1;
                ctrl_next[CTRL_ALU_OP_HI:CTRL_ALU_OP_LO] = ALU_IMM;
                if (opcode == OP_ANDI || opcode == OP_ORI) begin
                    imm_next = DATA_W'(if_instr[15:0]);
                end
            end
            OP_J: begin
                ctrl_next[CTRL_JUMP] = 1'b1;
            end
            OP_JAL: begin
                ctrl_next[CTRL_JUMP]      = 1'b1;
                ctrl_next[CTRL_REG_WRITE] = 1'b1;
                rd_next                   = '1;
            end
            default: supported = 1'b0;
        endcase
    end

    // rt is only a source operand for these formats; I-type rt is a destination.
    assign rt_used = (opcode == OP_RTYPE) || (opcode == OP_SW) ||
                     (opcode == OP_BEQ)   || (opcode == OP_BNE);
    assign stall   = !rst && !flush && if_valid && ex_mem_read && (ex_rt != '0) &&
                     ((ex_rt == rs) || ((ex_rt == rt) && rt_used));
    assign load    = if_valid && !flush && !stall;
    assign keep    = load && (supported || TRAP_EN);

    always_ff @(posedge clk) begin
        if (rst || !keep) begin
            id_valid   <= 1'b0;
            id_pc      <= '0;
            id_rs_data <= '0;
            id_rt_data <= '0;
            id_imm     <= '0;
            id_rs      <= '0;
            id_rt      <= '0;
            id_rd      <= '0;
            id_shamt   <= '0;
            id_funct   <= '0;
            id_jtarget <= '0;
            id_ctrl    <= '0;
`ifdef ILLEGAL_INSTR_TRAP_EN
            id_illegal <= 1'b0;
`endif
        end else begin
            id_valid   <= 1'b1;
            id_pc      <= if_pc;
            id_rs_data <= rs_data;
            id_rt_data <= rt_data;
            id_imm     <= imm_next;
            id_rs      <= rs;
            id_rt      <= rt;
            id_rd      <= rd_next;
            id_shamt   <= if_instr[10:6];
            id_funct   <= if_instr[5:0];
            id_jtarget <= if_instr[25:0];
            id_ctrl    <= supported ? ctrl_next : '0;
`ifdef ILLEGAL_INSTR_TRAP_EN
            id_illegal <= !supported;
`endif
        end
    end

endmodule

// File: tb/tb_instruction_decode.sv
// Testbench for instruction_decode: directed vector table, then randomized traffic against a reference model.
module tb_instruction_decode;

`ifdef ILLEGAL_INSTR_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        flush;
    logic        ex_mem_read;
    logic [4:0]  ex_rt;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        stall;
    logic        id_valid;
    logic [31:0] id_pc, id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
    logic [5:0]  id_funct;
    logic [25:0] id_jtarget;
    logic [9:0]  id_ctrl;
    logic        ill;

    always #5 clk = ~clk;

    instruction_decode dut (
        .clk         (clk),
        .rst         (rst),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .flush       (flush),
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .stall       (stall),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_rs_data  (id_rs_data),
        .id_rt_data  (id_rt_data),
        .id_imm      (id_imm),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_rd       (id_rd),
        .id_shamt    (id_shamt),
        .id_funct    (id_funct),
        .id_jtarget  (id_jtarget),
        .id_ctrl     (id_ctrl)
`ifdef ILLEGAL_INSTR_TRAP_EN
        ,
        .id_illegal  (ill)
`endif
    );
`ifndef ILLEGAL_INSTR_TRAP_EN
    assign ill = 1'b0;
`endif

    typedef logic [191:0] outv_t;

    typedef struct packed {
        logic        v;
        logic [31:0] instr;
        logic        fl;
        logic        mr;
        logic [4:0]  ert;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        e_stall;
        logic        e_valid;
        logic [9:0]  e_ctrl;
        logic [31:0] e_rs;
        logic [31:0] e_rt;
        logic [31:0] e_imm;
        logic [4:0]  e_rd;
    } vec_t;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] shadow [32];
    logic [9:0]  ctrl_of [64];
    bit          known [64];
    bit          funct_ok [64];

    task automatic check(input string name, input outv_t act, input outv_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    function automatic outv_t dut_out();
        return {id_valid, id_pc, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
                id_shamt, id_funct, id_jtarget, id_ctrl, ill};
    endfunction

    // Reference: operand read honours write-back of the same cycle.
    function automatic logic [31:0] rd_reg(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (wb_en && wb_addr == a) return wb_data;
        return shadow[a];
    endfunction

    function automatic bit model_stall();
        logic [5:0] op;
        logic [4:0] s, t;
        op = if_instr[31:26];
        s  = if_instr[25:21];
        t  = if_instr[20:16];
        if (rst || flush || !if_valid || !ex_mem_read || ex_rt == 0) return 1'b0;
        return (ex_rt == s) || (ex_rt == t && op inside {6'h00, 6'h2B, 6'h04, 6'h05});
    endfunction

    function automatic outv_t model_out();
        logic [5:0]  op;
        logic [31:0] imm;
        logic [4:0]  rd;
        bit          legal;
        op    = if_instr[31:26];
        legal = known[op] && (op != 6'h00 || funct_ok[if_instr[5:0]]);
        if (rst || flush || !if_valid || model_stall()) return '0;
        if (!legal && !TRAP) return '0;
        imm = (op == 6'h0C || op == 6'h0D) ? {16'h0, if_instr[15:0]}
                                           : {{16{if_instr[15]}}, if_instr[15:0]};
        rd  = (op == 6'h03) ? 5'd31 : if_instr[15:11];
        return {1'b1, if_pc, rd_reg(if_instr[25:21]), rd_reg(if_instr[20:16]), imm,
                if_instr[25:21], if_instr[20:16], rd, if_instr[10:6], if_instr[5:0],
                if_instr[25:0], legal ? ctrl_of[op] : 10'h0, !legal};
    endfunction

    task automatic commit_shadow();
        if (rst) begin
            for (int i = 0; i < 32; i++) shadow[i] = 32'h0;
        end else if (wb_en && wb_addr != 0) begin
            shadow[wb_addr] = wb_data;
        end
    endtask

    task automatic step_model(input string name);
        outv_t exp;
        #1;
        check({name, "_stall"}, outv_t'(stall), outv_t'(model_stall()));
        exp = model_out();
        @(posedge clk);
        commit_shadow();
        #1;
        check({name, "_out"}, dut_out(), exp);
    endtask

    vec_t tbl [14];

    initial begin
        logic [5:0] ops [11];
        logic [5:0] fl  [5];
        logic [5:0] op;
        logic [5:0] fn;
        outv_t      e;

        for (int i = 0; i < 64; i++) begin
            known[i] = 1'b0; ctrl_of[i] = 10'h0; funct_ok[i] = 1'b0;
        end
        known[6'h00] = 1; ctrl_of[6'h00] = 10'b1000010010;
        known[6'h23] = 1; ctrl_of[6'h23] = 10'b1101100000;
        known[6'h2B] = 1; ctrl_of[6'h2B] = 10'b0010100000;
        known[6'h04] = 1; ctrl_of[6'h04] = 10'b0000001001;
        known[6'h05] = 1; ctrl_of[6'h05] = 10'b0000001001;
        known[6'h08] = 1; ctrl_of[6'h08] = 10'b1000100011;
        known[6'h0C] = 1; ctrl_of[6'h0C] = 10'b1000100011;
        known[6'h0D] = 1; ctrl_of[6'h0D] = 10'b1000100011;
        known[6'h0A] = 1; ctrl_of[6'h0A] = 10'b1000100011;
        known[6'h02] = 1; ctrl_of[6'h02] = 10'b0000000100;
        known[6'h03] = 1; ctrl_of[6'h03] = 10'b1000000100;
        foreach (funct_ok[i]) begin
            funct_ok[i] = (i inside {0, 2, 3, 4, 6, 7, 8, 32, 33, 34, 35, 36, 37, 38, 39, 42, 43});
        end
        for (int i = 0; i < 32; i++) shadow[i] = 32'h0;

        //         v  instr         fl mr ert we wa  wd            stall val ctrl    rs            rt            imm           rd
        tbl[0]  = '{1, 32'h20080005, 0, 0, 0, 0, 0,  32'h0,        0, 1, 10'h223, 32'h0,        32'h0,        32'h5,        5'd0};
        tbl[1]  = '{1, 32'h01295020, 0, 0, 0, 1, 9,  32'hDEADBEEF, 0, 1, 10'h212, 32'hDEADBEEF, 32'hDEADBEEF, 32'h5020,     5'd10};
        tbl[2]  = '{1, 32'h00095020, 0, 0, 0, 1, 0,  32'hFFFFFFFF, 0, 1, 10'h212, 32'h0,        32'hDEADBEEF, 32'h5020,     5'd10};
        tbl[3]  = '{1, 32'h01285020, 0, 1, 9, 0, 0,  32'h0,        1, 0, 10'h000, 32'h0,        32'h0,        32'h0,        5'd0};
        tbl[4]  = '{1, 32'h01285020, 0, 0, 9, 0, 0,  32'h0,        0, 1, 10'h212, 32'hDEADBEEF, 32'h0,        32'h5020,     5'd10};
        tbl[5]  = '{1, 32'h01285020, 1, 1, 9, 0, 0,  32'h0,        0, 0, 10'h000, 32'h0,        32'h0,        32'h0,        5'd0};
        tbl[6]  = '{1, 32'hFC000000, 0, 0, 0, 0, 0,  32'h0,        0, TRAP, 10'h000, 32'h0,     32'h0,        32'h0,        5'd0};
        tbl[7]  = '{1, 32'h8D090004, 0, 0, 0, 0, 0,  32'h0,        0, 1, 10'h360, 32'h0,        32'hDEADBEEF, 32'h4,        5'd0};
        tbl[8]  = '{1, 32'hAD09FFFC, 0, 0, 0, 0, 0,  32'h0,        0, 1, 10'h0A0, 32'h0,        32'hDEADBEEF, 32'hFFFFFFFC, 5'd31};
        tbl[9]  = '{1, 32'h35098000, 0, 0, 0, 0, 0,  32'h0,        0, 1, 10'h223, 32'h0,        32'hDEADBEEF, 32'h8000,     5'd16};
        tbl[10] = '{1, 32'h0C000123, 0, 0, 0, 0, 0,  32'h0,        0, 1, 10'h204, 32'h0,        32'h0,        32'h123,      5'd31};
        tbl[11] = '{0, 32'h20080005, 0, 0, 0, 0, 0,  32'h0,        0, 0, 10'h000, 32'h0,        32'h0,        32'h0,        5'd0};
        tbl[12] = '{1, 32'h11280003, 0, 1, 8, 0, 0,  32'h0,        1, 0, 10'h000, 32'h0,        32'h0,        32'h0,        5'd0};
        tbl[13] = '{1, 32'h21280001, 0, 1, 8, 0, 0,  32'h0,        0, 1, 10'h223, 32'hDEADBEEF, 32'h0,        32'h1,        5'd0};

        rst = 1; if_valid = 0; if_instr = 0; if_pc = 0; flush = 0;
        ex_mem_read = 0; ex_rt = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
        repeat (5) @(posedge clk);
        #1;
        check("reset_out", dut_out(), '0);
        check("reset_stall", outv_t'(stall), '0);
        rst = 0;

        for (int i = 0; i < 14; i++) begin
            logic [31:0] pc;
            pc = 32'h40 + 32'(i * 4);
            if_valid = tbl[i].v; if_instr = tbl[i].instr; if_pc = pc; flush = tbl[i].fl;
            ex_mem_read = tbl[i].mr; ex_rt = tbl[i].ert;
            wb_en = tbl[i].we; wb_addr = tbl[i].wa; wb_data = tbl[i].wd;
            #1;
            check($sformatf("vec%0d_stall", i), outv_t'(stall), outv_t'(tbl[i].e_stall));
            @(posedge clk);
            commit_shadow();
            #1;
            check($sformatf("vec%0d_fields", i),
                  {id_valid, id_pc, id_ctrl, id_rs_data, id_rt_data, id_imm, id_rd},
                  {tbl[i].e_valid, tbl[i].e_valid ? pc : 32'h0, tbl[i].e_ctrl,
                   tbl[i].e_rs, tbl[i].e_rt, tbl[i].e_imm, tbl[i].e_rd});
            $display("vec %0d instr=%h stall=%0b valid=%0b ctrl=%h", i, tbl[i].instr,
                     stall, id_valid, id_ctrl);
        end

        // Reset arriving while a load-use stall is pending.
        wb_en = 1; wb_addr = 9; wb_data = 32'h12345678;
        if_valid = 1; if_instr = 32'h01285020; ex_mem_read = 1; ex_rt = 9; flush = 0;
        step_model("prestall");
        wb_en = 0;
        step_model("stall_held");
        rst = 1;
        step_model("rst_in_stall");
        rst = 0; ex_mem_read = 0;
        step_model("post_rst_read");

        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h02, 6'h03};
        fl  = '{6'h20, 6'h22, 6'h25, 6'h2A, 6'h00};
        for (int n = 0; n < 400; n++) begin
            op = ops[$urandom_range(0, 10)];
            fn = ($urandom_range(0, 5) == 0) ? 6'($urandom) : fl[$urandom_range(0, 4)];
            if_instr = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                        16'($urandom)};
            if (op == 6'h00) if_instr[5:0] = fn;
            if ($urandom_range(0, 9) == 0) if_instr = $urandom;
            if_pc       = $urandom & 32'hFFFFFFFC;
            if_valid    = ($urandom_range(0, 7) != 0);
            flush       = ($urandom_range(0, 9) == 0);
            ex_mem_read = ($urandom_range(0, 2) == 0);
            ex_rt       = 5'($urandom_range(0, 7));
            wb_en       = $urandom_range(0, 1) == 1;
            wb_addr     = 5'($urandom_range(0, 7));
            wb_data     = $urandom;
            rst         = ($urandom_range(0, 49) == 0);
            e = model_out();
            step_model($sformatf("rnd%0d", n));
            $display("rnd %0d instr=%h stall=%0b valid=%0b exp_valid=%0b", n, if_instr,
                     stall, id_valid, e[191]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
